// File: rtl/left_shift_sequencer_pkg.sv
// Shared types and defaults for the multi-cycle left shift sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } seq_state_t;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/left_shift_sequencer_if.sv
// Request/result handshake bundle between a requester and the shift sequencer.
interface left_shift_sequencer_if #(
  parameter int WIDTH = 32
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               StartValid;
  logic               StartReady;
  logic [WIDTH-1:0]   ValueIn;
  logic [SHAMT_W-1:0] ShiftAmount;
  logic               Abort;
  logic               ResultValid;
  logic               ResultReady;
  logic [WIDTH-1:0]   ValueOut;
  logic               Discarded;
  logic               Busy;

  modport master (
    output StartValid, ValueIn, ShiftAmount, Abort, ResultReady,
    input  StartReady, ResultValid, ValueOut, Discarded, Busy
  );

  modport slave (
    input  StartValid, ValueIn, ShiftAmount, Abort, ResultReady,
    output StartReady, ResultValid, ValueOut, Discarded, Busy
  );

endinterface

// File: rtl/left_shift_sequencer_shift.sv
// Single-bit left shift; the bit falling off the top is reported as CarryOut.
module shift_left_one_discard #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] DataIn,
  output logic [WIDTH-1:0] DataOut,
  output logic             CarryOut
);

  assign DataOut  = {DataIn[WIDTH-2:0], 1'b0};
  assign CarryOut = DataIn[WIDTH-1];

endmodule

// File: rtl/left_shift_sequencer.sv
// Variable left shifter that reuses one 1-bit shift stage for Count cycles,
// tracking whether any set bit was pushed out of the MSB.
module left_shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                   Clock,
  input logic                   ResetN,
  left_shift_sequencer_if.slave bus
);

  localparam int SHAMT_W = $clog2(WIDTH);

  seq_state_t         state;
  logic [SHAMT_W-1:0] count;
  logic [WIDTH-1:0]   valueReg;
  logic               discReg;
  logic [WIDTH-1:0]   shifted;
  logic               carry;

  shift_left_one_discard #(.WIDTH(WIDTH)) uShift (
    .DataIn   (valueReg),
    .DataOut  (shifted),
    .CarryOut (carry)
  );

  // Sequencer FSM plus working value, remaining count and sticky discard flag.
  // An abort leaves the datapath registers untouched; only the state unwinds.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state    <= IDLE;
      count    <= '0;
      valueReg <= '0;
      discReg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.StartValid) begin
            valueReg <= bus.ValueIn;
            count    <= bus.ShiftAmount;
            discReg  <= 1'b0;
            state    <= (bus.ShiftAmount == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          if (bus.Abort) begin
            state <= IDLE;
          end else begin
            valueReg <= shifted;
            discReg  <= discReg | carry;
            count    <= count - SHAMT_W'(1);
            if (count == SHAMT_W'(1)) state <= DONE;
          end
        end
        DONE: begin
          if (bus.ResultReady || bus.Abort) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.StartReady  = (state == IDLE);
  assign bus.ResultValid = (state == DONE);
  assign bus.Busy        = (state != IDLE);
  assign bus.ValueOut    = valueReg;
  assign bus.Discarded   = discReg;

endmodule
